// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// register file depth and the controller state encoding.
package regfile_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int ADDR_W_DEF  = 4;
   localparam int NUM_ENTRIES = 16;
   localparam int CNT_W       = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. ptr selects which requester wins when both
// are valid (0 = req0, 1 = req1); a lone valid requester always wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // Grant decode: at most one bit set, lone requester ignores the pointer
   always_comb begin
      grant[0] = valid[0] & (~valid[1] | ~ptr);
      grant[1] = valid[1] & (~valid[0] |  ptr);
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register file write-port arbiter for two requesters with round-robin
// priority and a registered write port. Optional power-up clear sequence
// that zeroes all 16 entries is compiled in when REGFILE_CLEAR_EN is defined;
// without it the block starts arbitrating right after reset and busy is 0.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy,
   output logic              grant_id
);

   logic              ptr_reg;
   logic              grant_id_reg;
   logic              rf_we_reg;
   logic [ADDR_W-1:0] rf_waddr_reg;
   logic [DATA_W-1:0] rf_wdata_reg;
   logic [1:0]        grant;
   logic [1:0]        ready;
   logic              run_active;
   logic              clear_active;
   logic [CNT_W-1:0]  clear_cnt;

`ifdef REGFILE_CLEAR_EN
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Clear sequencer: walk the counter over every entry, then hand over to RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_CLEAR;
         cnt_reg   <= '0;
      end else if (state_reg == ST_CLEAR) begin
         cnt_reg <= cnt_reg + 1'b1;
         if (cnt_reg == CNT_W'(NUM_ENTRIES - 1))
            state_reg <= ST_RUN;
      end
   end

   assign run_active   = (state_reg == ST_RUN);
   assign clear_active = (state_reg == ST_CLEAR);
   assign clear_cnt    = cnt_reg;
`else
   assign run_active   = 1'b1;
   assign clear_active = 1'b0;
   assign clear_cnt    = '0;
`endif

   assign busy = clear_active;

   rr_arb2 u_arb (
      .valid (ready_valid_pair()),
      .ptr   (ptr_reg),
      .grant (grant)
   );

   function automatic logic [1:0] ready_valid_pair();
      return {req1_valid, req0_valid};
   endfunction

   // Readiness is withheld while clearing and while reset is held so that
   // nothing is reported as accepted in a cycle whose transfer is discarded
   always_comb begin
      ready = grant & {2{run_active & ~rst}};
   end

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   // Write port, grant record and priority pointer; pointer moves only on a transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         rf_wdata_reg <= '0;
         grant_id_reg <= 1'b0;
         ptr_reg      <= 1'b0;
      end else if (clear_active) begin
         rf_we_reg    <= 1'b1;
         rf_waddr_reg <= ADDR_W'(clear_cnt);
         rf_wdata_reg <= '0;
      end else if (ready[0]) begin
         rf_we_reg    <= 1'b1;
         rf_waddr_reg <= req0_addr;
         rf_wdata_reg <= req0_data;
         grant_id_reg <= 1'b0;
         ptr_reg      <= 1'b1;
      end else if (ready[1]) begin
         rf_we_reg    <= 1'b1;
         rf_waddr_reg <= req1_addr;
         rf_wdata_reg <= req1_data;
         grant_id_reg <= 1'b1;
         ptr_reg      <= 1'b0;
      end else begin
         rf_we_reg    <= 1'b0;
      end
   end

   assign rf_we    = rf_we_reg;
   assign rf_waddr = rf_waddr_reg;
   assign rf_wdata = rf_wdata_reg;
   assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter. Works in both builds
// (REGFILE_CLEAR_EN defined or not). A transaction-level model decides the
// winner of each cycle from the round-robin rule and tracks the expected
// write port and register file contents.
module tb_regfile_wr_arbiter;

   localparam int DW = 8;
   localparam int AW = 4;
`ifdef REGFILE_CLEAR_EN
   localparam int CLR_CYC = 16;
`else
   localparam int CLR_CYC = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          busy;
   logic          grant_id;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   // Stand-in for the external register file driven by the write port
   logic [DW-1:0] rf_mem [16];
   always @(posedge clk) begin
      if (!rst && rf_we) rf_mem[rf_waddr] <= rf_wdata;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int            clear_left;
   int            pref;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic          m_gid;
   logic [DW-1:0] exp_mem [16];

   // Per-cycle observations and expectations
   logic          obs_r0, obs_r1, obs_we, obs_gid, obs_busy;
   logic [AW-1:0] obs_addr;
   logic [DW-1:0] obs_data;
   logic [16:0]   obs_vec, exp_vec;

   task automatic model_reset();
      clear_left = CLR_CYC;
      pref   = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_gid  = 1'b0;
   endtask

   // Drive one cycle of requests (called at posedge+1, returns at next posedge+1)
   task automatic apply_cycle(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      int win;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      @(negedge clk);
      obs_r0 = req0_ready; obs_r1 = req1_ready; obs_we = rf_we;
      obs_addr = rf_waddr; obs_data = rf_wdata; obs_gid = grant_id; obs_busy = busy;
      win = -1;
      if (clear_left == 0) begin
         if (v0 && v1) win = pref;
         else if (v0)  win = 0;
         else if (v1)  win = 1;
      end
      obs_vec = {obs_r0, obs_r1, obs_we, obs_addr, obs_data, obs_gid, obs_busy};
      exp_vec = {win == 0, win == 1, m_we, m_addr, m_data, m_gid, clear_left > 0};
      if (clear_left > 0) begin
         m_we = 1'b1;
         m_addr = 4'(CLR_CYC - clear_left);
         m_data = '0;
         exp_mem[m_addr] = '0;
         clear_left--;
      end else if (win >= 0) begin
         m_we   = 1'b1;
         m_addr = (win == 1) ? a1 : a0;
         m_data = (win == 1) ? d1 : d0;
         m_gid  = (win == 1);
         pref   = 1 - win;
         exp_mem[m_addr] = m_data;
      end else begin
         m_we = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      n_checks++;
      if ({rf_we, rf_waddr, rf_wdata, grant_id} !== 14'h0) begin
         n_fail++; $display("FAIL reset_outputs: got we=%b addr=%h data=%h gid=%b expected all 0",
                            rf_we, rf_waddr, rf_wdata, grant_id);
      end
      n_checks++;
      if (busy !== (CLR_CYC > 0)) begin
         n_fail++; $display("FAIL reset_busy: got %b expected %b", busy, CLR_CYC > 0);
      end
      $display("reset: ready=%b%b we=%b busy=%b", req0_ready, req1_ready, rf_we, busy);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_clear();
      int busy_cnt = 0;
      for (int i = 0; i < CLR_CYC + 3; i++) begin
         apply_cycle(1'b1, 4'd5, 8'hAA, 1'b1, 4'd9, 8'hBB);
         if (obs_busy) busy_cnt++;
         $display("clear cycle %0d: busy=%b we=%b addr=%0d data=%h", i, obs_busy, obs_we, obs_addr, obs_data);
         if (i < CLR_CYC) begin
            n_checks++;
            if (obs_vec !== exp_vec) begin
               n_fail++; $display("FAIL clear_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
            end
         end
      end
      // Requests offered during the clear are granted once RUN is reached;
      // the model tracked them, so settle and then compare the count
      n_checks++;
      if (busy_cnt !== CLR_CYC) begin
         n_fail++; $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_cnt, CLR_CYC);
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef REGFILE_CLEAR_EN
      for (int a = 0; a < 16; a++) begin
         n_checks++;
         if (rf_mem[a] !== exp_mem[a]) begin
            n_fail++; $display("FAIL clear_read addr %0d: got %h expected %h", a, rf_mem[a], exp_mem[a]);
         end
      end
`endif
      // Return the pointer to favour req0 for the contention scenario
      test_reset();
      for (int i = 0; i < CLR_CYC; i++) apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic test_contention();
      for (int i = 0; i < 4; i++) begin
         apply_cycle(1'b1, 4'd1, 8'd10, 1'b1, 4'd2, 8'd20);
         $display("contention cycle %0d: ready=%b%b gid=%b", i, obs_r0, obs_r1, obs_gid);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL contention_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         n_checks++;
         if ({obs_r0, obs_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL contention_grant %0d: got %b%b expected %0d", i, obs_r0, obs_r1, i % 2);
         end
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      n_checks++;
      if (obs_vec !== exp_vec || obs_gid !== 1'b1 || obs_addr !== 4'd2) begin
         n_fail++; $display("FAIL contention_tail: got %h expected %h", obs_vec, exp_vec);
      end
   endtask

   task automatic test_same_addr();
      logic p0 = 1'b1, p1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_cycle(p0, 4'd3, 8'd7, p1, 4'd3, 8'd9);
         $display("same_addr cycle %0d: ready=%b%b we=%b addr=%0d data=%0d", i, obs_r0, obs_r1, obs_we, obs_addr, obs_data);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL same_addr_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (i == 0) begin
            n_checks++;
            if (obs_r0 !== 1'b1) begin
               n_fail++; $display("FAIL same_addr_first: got ready0=%b expected 1", obs_r0);
            end
         end
         if (obs_r0) p0 = 1'b0;
         if (obs_r1) p1 = 1'b0;
      end
      n_checks++;
      if (rf_mem[3] !== 8'd9) begin
         n_fail++; $display("FAIL same_addr_read: got %0d expected 9", rf_mem[3]);
      end
   endtask

   task automatic test_single();
      apply_cycle(1'b1, 4'd6, 8'd55, 1'b0, '0, '0);
      $display("single: ready=%b%b", obs_r0, obs_r1);
      n_checks++;
      if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0 || obs_vec !== exp_vec) begin
         n_fail++; $display("FAIL single_ready: got %h expected %h", obs_vec, exp_vec);
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      $display("single write: we=%b addr=%0d data=%0d", obs_we, obs_addr, obs_data);
      n_checks++;
      if (obs_we !== 1'b1 || obs_addr !== 4'd6 || obs_data !== 8'd55) begin
         n_fail++; $display("FAIL single_write: got we=%b addr=%0d data=%0d expected 1/6/55", obs_we, obs_addr, obs_data);
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      n_checks++;
      if (rf_mem[6] !== 8'd55) begin
         n_fail++; $display("FAIL single_read: got %0d expected 55", rf_mem[6]);
      end
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
         n_checks++;
         if (obs_vec !== exp_vec || (i > 0 && obs_we !== 1'b0)) begin
            n_fail++; $display("FAIL idle_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
      end
      $display("idle: 10 cycles done, we=%b", obs_we);
      apply_cycle(1'b0, '0, '0, 1'b1, 4'd12, 8'h5C);
      $display("idle lone req1: ready=%b%b", obs_r0, obs_r1);
      n_checks++;
      if (obs_r1 !== 1'b1 || obs_vec !== exp_vec) begin
         n_fail++; $display("FAIL idle_lone_req1: got %h expected %h", obs_vec, exp_vec);
      end
      apply_cycle(1'b1, 4'd13, 8'h11, 1'b1, 4'd14, 8'h22);
      n_checks++;
      if (obs_r0 !== 1'b1 || obs_vec !== exp_vec) begin
         n_fail++; $display("FAIL idle_pointer: got %h expected %h", obs_vec, exp_vec);
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic test_random();
      logic          p0 = 1'b0, p1 = 1'b0;
      logic [AW-1:0] a0 = '0, a1 = '0;
      logic [DW-1:0] d0 = '0, d1 = '0;
      int errs = 0;
      for (int i = 0; i < 300; i++) begin
         if (!p0 && $urandom_range(2) != 0) begin
            p0 = 1'b1; a0 = 4'($urandom); d0 = 8'($urandom);
         end
         if (!p1 && $urandom_range(2) != 0) begin
            p1 = 1'b1; a1 = 4'($urandom); d1 = 8'($urandom);
         end
         apply_cycle(p0, a0, d0, p1, a1, d1);
         $display("random cycle %0d: v=%b%b ready=%b%b we=%b addr=%0d data=%h", i, p0, p1, obs_r0, obs_r1, obs_we, obs_addr, obs_data);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL random_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
         if (obs_r0) p0 = 1'b0;
         if (obs_r1) p1 = 1'b0;
      end
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      for (int a = 0; a < 16; a++) begin
         n_checks++;
         if (rf_mem[a] !== exp_mem[a]) begin
            n_fail++; $display("FAIL random_read addr %0d: got %h expected %h", a, rf_mem[a], exp_mem[a]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int busy_cnt = 0;
`ifdef REGFILE_CLEAR_EN
      test_reset();
      for (int i = 0; i < 8; i++) apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
`else
      apply_cycle(1'b1, 4'd5, 8'h33, 1'b0, '0, '0);
`endif
      test_reset();
      for (int i = 0; i < CLR_CYC + 2; i++) begin
         apply_cycle(1'b0, '0, '0, 1'b0, '0, '0);
         if (obs_busy) busy_cnt++;
         $display("reset_mid cycle %0d: busy=%b we=%b addr=%0d", i, obs_busy, obs_we, obs_addr);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++; $display("FAIL reset_mid_cycle %0d: got %h expected %h", i, obs_vec, exp_vec);
         end
      end
      n_checks++;
      if (busy_cnt !== CLR_CYC) begin
         n_fail++; $display("FAIL reset_mid_busy_cycles: got %0d expected %0d", busy_cnt, CLR_CYC);
      end
   endtask

   initial begin
      for (int a = 0; a < 16; a++) begin
         rf_mem[a]  = 8'hFF;
         exp_mem[a] = 8'hFF;
      end
      model_reset();
      @(posedge clk); #1;
      test_reset();
      test_clear();
      test_contention();
      test_same_addr();
      test_single();
      test_idle();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the register file data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the register file address width (16 entries).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1: requester write request.
REQ-006 The block SHALL have ports req0_addr / req1_addr, input, ADDR_W: requester target register.
REQ-007 The block SHALL have ports req0_data / req1_data, input, DATA_W: requester write data.
REQ-008 The block SHALL have ports req0_ready / req1_ready, output, 1: request accepted this cycle.
REQ-009 The block SHALL have port rf_we, output, 1: register file write enable, registered.
REQ-010 The block SHALL have port rf_waddr, output, ADDR_W: register file write address, registered.
REQ-011 The block SHALL have port rf_wdata, output, DATA_W: register file write data, registered.
REQ-012 The block SHALL have port busy, output, 1: high while the clear sequence runs.
REQ-013 The block SHALL have port grant_id, output, 1: index of the last accepted requester, registered.

Function
REQ-014 States: CLEAR and RUN. A transfer occurs when reqN_valid && reqN_ready in the same cycle.
REQ-015 reqN_ready: combinational; never high in CLEAR; at most one ready high per cycle.
REQ-016 RUN, only one valid: that requester gets ready=1 regardless of priority.
REQ-017 RUN, both valid: the requester other than the one last granted wins (round-robin); after reset req0 wins first.
REQ-018 Priority pointer: flips only on an actual transfer; it does not flip on idle cycles.
REQ-019 Transfer in cycle N: rf_we=1 with that request's addr/data in cycle N+1 (latency 1); otherwise rf_we=0 in cycle N+1, addr/data hold.
REQ-020 Throughput: one write per cycle sustained; back-to-back transfers alternate under continuous contention.
REQ-021 Both requesters targeting the same address: arbitrate normally; the later write wins in the register file; no merging.
REQ-022 A requester SHALL hold valid/addr/data stable until accepted; the block does not latch unaccepted requests.
REQ-023 CLEAR: 4-bit counter 0..15; each cycle rf_we=1, rf_waddr=counter, rf_wdata=0; after entry 15 is written -> RUN.
REQ-024 busy=1 for exactly the 16 CLEAR cycles and 0 in RUN.

Reset
REQ-025 rst high: rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, pointer favours req0, counter=0, ready outputs 0.
REQ-026 Reset during CLEAR or RUN restarts at the post-reset state; a transfer accepted in the cycle reset asserts is discarded.
REQ-027 Post-reset state: CLEAR with busy=1 when REGFILE_CLEAR_EN is defined, otherwise RUN with busy=0.

Configuration
REQ-028 Macro REGFILE_CLEAR_EN defined: the CLEAR state and counter are compiled in per REQ-023/024.
REQ-029 REGFILE_CLEAR_EN undefined: no CLEAR logic; busy tied 0; arbitration starts the first cycle after reset.

Structure
REQ-030 Shared package regfile_pkg: DATA_W/ADDR_W defaults, entry count (16), and the state encoding (CLEAR, RUN).
REQ-031 Sub-module rr_arb2: 2-way round-robin arbiter; inputs valid pair and pointer; outputs grant pair.
REQ-032 The register file is instantiated outside this block; this block drives only its write port.

Verification
REQ-033 With REGFILE_CLEAR_EN: release rst, preload register file with 0xFF -> busy high 16 cycles, rf_we to addr 0..15 with data 0, then all reads return 0.
REQ-034 Single requester: req0 valid, addr 6, data 55 -> req0_ready same cycle; next cycle rf_we=1, rf_waddr=6, rf_wdata=55; read of addr 6 returns 55.
REQ-035 Contention: both valid for 4 cycles (req0 addr 1 data 10, req1 addr 2 data 20) -> grants 0,1,0,1; grant_id follows; never both ready.
REQ-036 Same address: req0 and req1 both addr 3 with data 7 and 9 -> req0 accepted first, req1 next; final read of addr 3 returns 9.
REQ-037 Reset mid-CLEAR at counter 8 -> outputs return to reset values; clear restarts at addr 0 and runs a full 16 cycles.
REQ-038 Idle: no valid for 10 cycles -> rf_we stays 0; the pointer is unchanged and the next lone req1 is accepted immediately.
